// File: rtl/pps_seq_pkg.sv
// pps_seq_pkg
//   Shared definitions for the PPS lock sequencer: the sequencer state type
//   (with its externally visible encodings) and the function that derives the
//   missing-PPS timeout, in clock cycles, from the nominal clock rate.
//   Ports: none (package).
//   Optional build macro used by the sequencer files: PPS_SEQ_HOLDOVER_TIMER_EN.

package pps_seq_pkg;

    // Encodings are visible on o_state, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_TRACK    = 2'd2,
        ST_HOLDOVER = 2'd3
    } seq_state_t;

    // A PPS edge is declared missing after one nominal second plus 1/8 s
    // of slack, measured from the last PPS.
    function automatic int miss_timeout(input int clk_hz);
        return clk_hz + clk_hz / 8;
    endfunction

endpackage

// File: rtl/pps_seq_timeout.sv
// pps_seq_timeout
//   Cycle counting for the PPS lock sequencer.
//   - Miss counter: cleared by every PPS, counts clock cycles otherwise and
//     saturates at the miss timeout. miss_hit is high while the current cycle
//     is the timeout-th (or later) cycle since the last PPS.
//   - Holdover seconds counter (only with PPS_SEQ_HOLDOVER_TIMER_EN defined):
//     counts CLK_HZ-cycle seconds while in_holdover is high; hold_expire
//     pulses in the last cycle of the HOLD_MAX_S-th second. Without the macro
//     hold_expire is constant 0 and no seconds counter exists.
//   Ports:
//     clk          in   clock, rising edge
//     srst         in   synchronous active-high reset
//     pps          in   PPS pulse (synchronised)
//     in_holdover  in   sequencer currently in HOLDOVER
//     miss_hit     out  miss timeout reached this cycle
//     hold_expire  out  holdover limit reached this cycle

module pps_seq_timeout
    import pps_seq_pkg::*;
#(
    parameter int CLK_HZ     = 156250000,
    parameter int HOLD_MAX_S = 3600
) (
    input  logic clk,
    input  logic srst,
    input  logic pps,
    input  logic in_holdover,
    output logic miss_hit,
    output logic hold_expire
);

    localparam int MISS_LIMIT = miss_timeout(CLK_HZ);
    localparam int MISS_W     = $clog2(MISS_LIMIT + 1);

    logic [MISS_W-1:0] miss_cnt_reg;

    // Counter value k during a cycle means that cycle is the (k+1)-th since
    // the PPS cycle, so the timeout fires at MISS_LIMIT-1.
    always_ff @(posedge clk) begin
        if (srst || pps) begin
            miss_cnt_reg <= '0;
        end else if (miss_cnt_reg != MISS_W'(MISS_LIMIT)) begin
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
    end

    assign miss_hit = (miss_cnt_reg >= MISS_W'(MISS_LIMIT - 1));

`ifdef PPS_SEQ_HOLDOVER_TIMER_EN
    localparam int SUB_W = $clog2(CLK_HZ + 1);
    localparam int SEC_W = $clog2(HOLD_MAX_S + 1);

    logic [SUB_W-1:0] tick_cnt_reg;
    logic [SEC_W-1:0] sec_cnt_reg;
    logic             sec_wrap;

    assign sec_wrap = (tick_cnt_reg == SUB_W'(CLK_HZ - 1));

    // Both counters restart whenever the sequencer is outside HOLDOVER, so
    // each holdover episode gets a full HOLD_MAX_S budget.
    always_ff @(posedge clk) begin
        if (srst || !in_holdover) begin
            tick_cnt_reg <= '0;
            sec_cnt_reg  <= '0;
        end else if (sec_wrap) begin
            tick_cnt_reg <= '0;
            if (sec_cnt_reg != SEC_W'(HOLD_MAX_S)) begin
                sec_cnt_reg <= sec_cnt_reg + 1'b1;
            end
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    assign hold_expire = in_holdover && sec_wrap &&
                         (sec_cnt_reg == SEC_W'(HOLD_MAX_S - 1));
`else
    logic unused_hold;
    assign unused_hold = in_holdover | (HOLD_MAX_S < 0);
    assign hold_expire = 1'b0;
`endif

endmodule

// File: rtl/pps_lock_sequencer.sv
// pps_lock_sequencer
//   Supervises a PPS tracking loop: qualifies the loop's phase error against
//   a lock threshold, walks IDLE -> ACQUIRE -> TRACK, drops to HOLDOVER when
//   PPS disappears, and hands the loop the coefficient set for each state.
//   All outputs are registered; an input event at cycle n shows at n+1.
//   Optional build macro: PPS_SEQ_HOLDOVER_TIMER_EN (holdover time limit;
//   without it HOLDOVER lasts until the next PPS and o_expired stays 0).
//   Ports:
//     i_clk        in   clock, rising edge
//     i_rst        in   synchronous active-high reset
//     i_pps        in   one-cycle PPS pulse, synchronised to i_clk
//     i_err_valid  in   one-cycle strobe qualifying i_err
//     i_err        in   signed phase error [ERR_W]
//     o_pcoef      out  phase coefficient [COEF_W]
//     o_fcoef      out  frequency coefficient [COEF_W]
//     o_coef_ld    out  one-cycle pulse, coefficients changed
//     o_freeze     out  hold loop frequency word
//     o_state      out  state encoding [2]
//     o_locked     out  loop locked
//     o_holdover   out  PPS lost, coasting on last frequency
//     o_expired    out  holdover limit reached (sticky until PPS or reset)

module pps_lock_sequencer
    import pps_seq_pkg::*;
#(
    parameter int CLK_HZ      = 156250000,
    parameter int ERR_W       = 32,
    parameter int COEF_W      = 8,
    parameter int LOCK_THRESH = 1000,
    parameter int LOCK_COUNT  = 8,
    parameter int LOSE_COUNT  = 3,
    parameter int ACQ_PCOEF   = 6,
    parameter int ACQ_FCOEF   = 12,
    parameter int TRK_PCOEF   = 10,
    parameter int TRK_FCOEF   = 20,
    parameter int HOLD_MAX_S  = 3600
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pps,
    input  logic                    i_err_valid,
    input  logic signed [ERR_W-1:0] i_err,
    output logic [COEF_W-1:0]       o_pcoef,
    output logic [COEF_W-1:0]       o_fcoef,
    output logic                    o_coef_ld,
    output logic                    o_freeze,
    output logic [1:0]              o_state,
    output logic                    o_locked,
    output logic                    o_holdover,
    output logic                    o_expired
);

    localparam int CNT_MAX = (LOCK_COUNT > LOSE_COUNT) ? LOCK_COUNT : LOSE_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ABS_W   = ERR_W + 1;

    localparam logic [COEF_W-1:0] ACQ_P  = COEF_W'(ACQ_PCOEF);
    localparam logic [COEF_W-1:0] ACQ_F  = COEF_W'(ACQ_FCOEF);
    localparam logic [COEF_W-1:0] TRK_P  = COEF_W'(TRK_PCOEF);
    localparam logic [COEF_W-1:0] TRK_F  = COEF_W'(TRK_FCOEF);
    localparam logic [ABS_W-1:0]  THRESH = ABS_W'(LOCK_THRESH);

    // ---------------- error qualification ----------------
    // Magnitude is taken one bit wider so the most-negative input cannot
    // wrap; that value is still forced out of bound explicitly.
    logic signed [ABS_W-1:0] err_ext;
    logic [ABS_W-1:0]        err_abs;
    logic                    err_is_min;
    logic                    err_in_bound;

    assign err_ext      = {i_err[ERR_W-1], i_err};
    assign err_abs      = err_ext[ABS_W-1] ? ABS_W'(-err_ext) : ABS_W'(err_ext);
    assign err_is_min   = i_err[ERR_W-1] && (i_err[ERR_W-2:0] == '0);
    assign err_in_bound = !err_is_min && (err_abs < THRESH);

    // ---------------- registers ----------------
    seq_state_t        state_reg, state_next;
    logic [COEF_W-1:0] pcoef_reg, pcoef_next;
    logic [COEF_W-1:0] fcoef_reg, fcoef_next;
    logic              coef_ld_reg, coef_ld_next;
    logic              freeze_reg, freeze_next;
    logic              locked_reg, locked_next;
    logic              holdover_reg, holdover_next;
    logic              expired_reg, expired_next;
    logic [CNT_W-1:0]  good_reg, good_next;
    logic [CNT_W-1:0]  bad_reg, bad_next;

    logic miss_hit;
    logic hold_expire;

    pps_seq_timeout #(
        .CLK_HZ     (CLK_HZ),
        .HOLD_MAX_S (HOLD_MAX_S)
    ) u_timeout (
        .clk         (i_clk),
        .srst        (i_rst),
        .pps         (i_pps),
        .in_holdover (state_reg == ST_HOLDOVER),
        .miss_hit    (miss_hit),
        .hold_expire (hold_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            pcoef_reg    <= ACQ_P;
            fcoef_reg    <= ACQ_F;
            coef_ld_reg  <= 1'b0;
            freeze_reg   <= 1'b0;
            locked_reg   <= 1'b0;
            holdover_reg <= 1'b0;
            expired_reg  <= 1'b0;
            good_reg     <= '0;
            bad_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pcoef_reg    <= pcoef_next;
            fcoef_reg    <= fcoef_next;
            coef_ld_reg  <= coef_ld_next;
            freeze_reg   <= freeze_next;
            locked_reg   <= locked_next;
            holdover_reg <= holdover_next;
            expired_reg  <= expired_next;
            good_reg     <= good_next;
            bad_reg      <= bad_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pcoef_next    = pcoef_reg;
        fcoef_next    = fcoef_reg;
        coef_ld_next  = 1'b0;
        freeze_next   = freeze_reg;
        locked_next   = locked_reg;
        holdover_next = holdover_reg;
        expired_next  = expired_reg;
        good_next     = good_reg;
        bad_next      = bad_reg;

        // Transition decision. A PPS in the same cycle as the miss timeout
        // wins (the timer is being cleared); the timeout wins over a strobe.
        case (state_reg)
            ST_IDLE: begin
                if (i_pps) state_next = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (miss_hit && !i_pps) begin
                    state_next = ST_HOLDOVER;
                end else if (i_err_valid) begin
                    if (!err_in_bound) begin
                        good_next = '0;
                    end else if (good_reg == CNT_W'(LOCK_COUNT - 1)) begin
                        state_next = ST_TRACK;
                    end else begin
                        good_next = good_reg + 1'b1;
                    end
                end
            end
            ST_TRACK: begin
                if (miss_hit && !i_pps) begin
                    state_next = ST_HOLDOVER;
                end else if (i_err_valid) begin
                    if (err_in_bound) begin
                        bad_next = '0;
                    end else if (bad_reg == CNT_W'(LOSE_COUNT - 1)) begin
                        state_next = ST_ACQUIRE;
                    end else begin
                        bad_next = bad_reg + 1'b1;
                    end
                end
            end
            default: begin  // ST_HOLDOVER
                if (i_pps) begin
                    state_next = ST_ACQUIRE;
                end else if (hold_expire) begin
                    state_next = ST_IDLE;
                end
            end
        endcase

        // Entry actions, shared by every path into a given state.
        if (state_next != state_reg) begin
            good_next = '0;
            bad_next  = '0;
            case (state_next)
                ST_ACQUIRE: begin
                    pcoef_next    = ACQ_P;
                    fcoef_next    = ACQ_F;
                    coef_ld_next  = 1'b1;
                    locked_next   = 1'b0;
                    freeze_next   = 1'b0;
                    holdover_next = 1'b0;
                    expired_next  = 1'b0;
                end
                ST_TRACK: begin
                    pcoef_next   = TRK_P;
                    fcoef_next   = TRK_F;
                    coef_ld_next = 1'b1;
                    locked_next  = 1'b1;
                end
                ST_HOLDOVER: begin
                    freeze_next   = 1'b1;
                    holdover_next = 1'b1;
                    locked_next   = 1'b0;
                end
                default: begin  // ST_IDLE, reachable only by holdover expiry
                    expired_next  = 1'b1;
                    freeze_next   = 1'b0;
                    holdover_next = 1'b0;
                    locked_next   = 1'b0;
                end
            endcase
        end
    end

    assign o_state    = state_reg;
    assign o_pcoef    = pcoef_reg;
    assign o_fcoef    = fcoef_reg;
    assign o_coef_ld  = coef_ld_reg;
    assign o_freeze   = freeze_reg;
    assign o_locked   = locked_reg;
    assign o_holdover = holdover_reg;
`ifdef PPS_SEQ_HOLDOVER_TIMER_EN
    assign o_expired  = expired_reg;
`else
    assign o_expired  = 1'b0;
`endif

endmodule

// File: tb/tb_pps_lock_sequencer.sv
// tb_pps_lock_sequencer
//   Scoreboard bench for pps_lock_sequencer. A driver applies one input
//   vector per cycle (directed phases plus $urandom strobes, error values and
//   PPS gaps), steps a behavioural model and queues the expected output
//   vector; a monitor pops and compares one vector per clock, one cycle later.
//   Honours PPS_SEQ_HOLDOVER_TIMER_EN for the holdover expiry expectation.

module tb_pps_lock_sequencer;

    localparam int CLK_HZ      = 1000;
    localparam int ERR_W       = 32;
    localparam int COEF_W      = 8;
    localparam int LOCK_THRESH = 100;
    localparam int LOCK_COUNT  = 4;
    localparam int LOSE_COUNT  = 2;
    localparam int HOLD_MAX_S  = 2;
    localparam int MISS_CYC    = CLK_HZ + CLK_HZ / 8;   // 1125

    logic                    i_clk = 1'b0;
    logic                    i_rst = 1'b1;
    logic                    i_pps = 1'b0;
    logic                    i_err_valid = 1'b0;
    logic signed [ERR_W-1:0] i_err = '0;
    logic [COEF_W-1:0]       o_pcoef, o_fcoef;
    logic                    o_coef_ld, o_freeze, o_locked, o_holdover, o_expired;
    logic [1:0]              o_state;

    pps_lock_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .ERR_W       (ERR_W),
        .COEF_W      (COEF_W),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSE_COUNT  (LOSE_COUNT),
        .ACQ_PCOEF   (6),
        .ACQ_FCOEF   (12),
        .TRK_PCOEF   (10),
        .TRK_FCOEF   (20),
        .HOLD_MAX_S  (HOLD_MAX_S)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pps       (i_pps),
        .i_err_valid (i_err_valid),
        .i_err       (i_err),
        .o_pcoef     (o_pcoef),
        .o_fcoef     (o_fcoef),
        .o_coef_ld   (o_coef_ld),
        .o_freeze    (o_freeze),
        .o_state     (o_state),
        .o_locked    (o_locked),
        .o_holdover  (o_holdover),
        .o_expired   (o_expired)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] p;
        logic [7:0] f;
        logic       ld;
        logic       frz;
        logic       lk;
        logic       hd;
        logic       ex;
    } outv_t;

    outv_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // ---------------- behavioural model ----------------
    // State kept as plain integers: which mode we are in, how many
    // consecutive good/bad errors, cycles since the last PPS, cycles spent
    // in holdover. Outputs follow from which mode we end up in.
    int    m_mode = 0;       // 0 idle, 1 acquire, 2 track, 3 holdover
    int    m_good = 0;
    int    m_bad  = 0;
    int    m_since = 0;      // cycles elapsed since the PPS cycle
    int    m_hold = 0;       // holdover cycles already completed
    outv_t m_out;

    task automatic model_step(input bit rst, input bit pps, input bit ev, input longint err);
        outv_t o;
        int    nm;
        bit    inb, timeout, expire;
        o    = m_out;
        o.ld = 1'b0;
        if (rst) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_since = 0; m_hold = 0;
            o = '{st: 2'd0, p: 8'd6, f: 8'd12, ld: 1'b0, frz: 1'b0, lk: 1'b0, hd: 1'b0, ex: 1'b0};
        end else begin
            inb     = (err != -longint'(64'sd2147483648)) && (err > -LOCK_THRESH) && (err < LOCK_THRESH);
            timeout = (m_since + 1 >= MISS_CYC) && !pps;
            expire  = 1'b0;
`ifdef PPS_SEQ_HOLDOVER_TIMER_EN
            expire  = (m_mode == 3) && (m_hold + 1 == CLK_HZ * HOLD_MAX_S);
`endif
            nm = m_mode;
            if (m_mode == 0) begin
                if (pps) nm = 1;
            end else if (m_mode == 3) begin
                if (pps) nm = 1;
                else if (expire) nm = 0;
            end else if (timeout) begin
                nm = 3;
            end else if (ev && m_mode == 1) begin
                m_good = inb ? m_good + 1 : 0;
                if (m_good == LOCK_COUNT) nm = 2;
            end else if (ev && m_mode == 2) begin
                m_bad = inb ? 0 : m_bad + 1;
                if (m_bad == LOSE_COUNT) nm = 1;
            end
            if (nm != m_mode) begin
                m_good = 0;
                m_bad  = 0;
                case (nm)
                    1: begin o.p = 8'd6;  o.f = 8'd12; o.ld = 1'b1; o.lk = 1'b0;
                             o.frz = 1'b0; o.hd = 1'b0; o.ex = 1'b0; end
                    2: begin o.p = 8'd10; o.f = 8'd20; o.ld = 1'b1; o.lk = 1'b1; end
                    3: begin o.frz = 1'b1; o.hd = 1'b1; o.lk = 1'b0; end
                    default: begin o.ex = 1'b1; o.frz = 1'b0; o.hd = 1'b0; o.lk = 1'b0; end
                endcase
            end
            m_hold  = (m_mode == 3 && nm == 3) ? m_hold + 1 : 0;
            m_since = pps ? 0 : ((m_since < 1000000) ? m_since + 1 : m_since);
            m_mode  = nm;
            o.st    = 2'(nm);
        end
        m_out = o;
        exp_q.push_back(o);
    endtask

    // ---------------- driver ----------------
    int drv_since = 0;   // cycles since the last PPS the driver issued
    int gap_target = 0;  // auto-PPS spacing; 0 disables auto PPS
    bit rand_gap = 1'b0; // re-randomise spacing after each auto PPS

    task automatic tick(input bit ev, input logic signed [ERR_W-1:0] err,
                        input bit rst = 1'b0, input bit force_pps = 1'b0);
        bit pps;
        @(negedge i_clk);
        pps = force_pps || (gap_target > 0 && drv_since + 1 >= gap_target);
        i_rst       = rst;
        i_pps       = pps;
        i_err_valid = ev;
        i_err       = ev ? err : $signed($urandom);
        model_step(rst, pps, ev, longint'(err));
        drv_since = pps ? 0 : drv_since + 1;
        if (pps && rand_gap) gap_target = $urandom_range(700, 1124);
    endtask

    function automatic logic signed [ERR_W-1:0] rand_err(input bit favour_in);
        int sel;
        int mag;
        sel = $urandom_range(0, 9);
        mag = 0;
        case (sel)
            0: return 32'sh8000_0000;
            1: return ($urandom_range(0, 1) == 1) ? 32'sd99 : -32'sd99;
            2: return ($urandom_range(0, 1) == 1) ? 32'sd100 : -32'sd100;
            default: begin
                if (favour_in ^ (sel == 9))
                    return $signed($urandom_range(0, 198)) - 32'sd99;
                mag = $urandom_range(100, 100000);
                return ($urandom_range(0, 1) == 1) ? mag : -mag;
            end
        endcase
    endfunction

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) tick(1'b1, rand_err(1'b1));
            else tick(1'b0, '0);
        end
    endtask

    task automatic strobe(input logic signed [ERR_W-1:0] err);
        tick(1'b1, err);
        tick(1'b0, '0);
        tick(1'b0, '0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        outv_t e, a;
        logic [1:0] prev_st;
        prev_st = 2'd0;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: o_state, p: o_pcoef, f: o_fcoef, ld: o_coef_ld, frz: o_freeze,
                      lk: o_locked, hd: o_holdover, ex: o_expired};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got st=%0d p=%0d f=%0d ld=%b frz=%b lk=%b hd=%b ex=%b required st=%0d p=%0d f=%0d ld=%b frz=%b lk=%b hd=%b ex=%b",
                             $time, a.st, a.p, a.f, a.ld, a.frz, a.lk, a.hd, a.ex,
                             e.st, e.p, e.f, e.ld, e.frz, e.lk, e.hd, e.ex);
                end else if (a.st != prev_st || a.ld) begin
                    $display("txn t=%0t state %0d->%0d p=%0d f=%0d ld=%b lk=%b hd=%b ex=%b",
                             $time, prev_st, a.st, a.p, a.f, a.ld, a.lk, a.hd, a.ex);
                end
                prev_st = a.st;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        m_out = '{st: 2'd0, p: 8'd6, f: 8'd12, ld: 1'b0, frz: 1'b0, lk: 1'b0, hd: 1'b0, ex: 1'b0};

        repeat (3) tick(1'b0, '0, 1'b1);
        idle_ticks(99);                         // strobes ignored in IDLE
        tick(1'b0, '0, 1'b0, 1'b1);             // first PPS -> ACQUIRE
        gap_target = 950;

        // Lock with a clearing out-of-bound value in the run, then unlock.
        strobe(50); strobe(50); strobe(-100);
        strobe(50); strobe(50); strobe(50); strobe(50);
        strobe(500); strobe(20); strobe(500);   // stays in TRACK
        strobe(500);                            // second consecutive -> ACQUIRE
        strobe(32'sh8000_0000);
        strobe(-99); strobe(99); strobe(0); strobe(-99);

        // Randomised traffic with random PPS spacing and one mid-run reset.
        rand_gap = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2345) tick(1'b0, '0, 1'b1);
            else if ($urandom_range(0, 5) == 0) tick(1'b1, rand_err(((i / 500) % 2) == 0));
            else tick(1'b0, '0);
        end

        // PPS exactly at the timeout cycle: no holdover.
        rand_gap = 1'b0;
        gap_target = 0;
        tick(1'b0, '0, 1'b0, 1'b1);
        idle_ticks(MISS_CYC - 1);
        tick(1'b0, '0, 1'b0, 1'b1);

        // PPS withheld: holdover, then expiry (or persistence), then recovery.
        idle_ticks(MISS_CYC + CLK_HZ * HOLD_MAX_S + 40);
        tick(1'b0, '0, 1'b0, 1'b1);
        strobe(10); strobe(-10); strobe(3); strobe(7);
        idle_ticks(MISS_CYC + 300);
        tick(1'b1, 32'sd5, 1'b1, 1'b1);         // reset overrides PPS and strobe
        idle_ticks(5);

        repeat (3) @(negedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
